// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the button conditioner: repeat FSM encoding and default timing.
// Defaults target a 100 MHz board clock (2.5 ms debounce, 250 ms delay, 50 ms repeat).
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    BC_IDLE   = 2'd0,
    BC_HOLD   = 2'd1,
    BC_REPEAT = 2'd2
  } bc_state_t;

  localparam int BC_DEF_N            = 4;
  localparam int BC_DEF_SYNC_STAGES  = 2;
  localparam int BC_DEF_DB_CYCLES    = 250000;
  localparam int BC_DEF_REPEAT_DELAY = 25000000;
  localparam int BC_DEF_REPEAT_RATE  = 5000000;

  function automatic int bc_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_conditioner_btn_channel.sv
// One conditioner channel: input synchroniser, stable-count debouncer,
// press/release strobes and the hold-to-repeat fire FSM.
module btn_channel
  import button_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES  = BC_DEF_SYNC_STAGES,
  parameter int DB_CYCLES    = BC_DEF_DB_CYCLES,
  parameter int REPEAT_DELAY = BC_DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = BC_DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  input  logic repeat_en,
  output logic level,
  output logic press,
  output logic released,
  output logic fire,
  output logic held_long
);

  localparam int DB_W  = $clog2(DB_CYCLES);
  localparam int RPT_W = $clog2(bc_max(REPEAT_DELAY, REPEAT_RATE) + 1);

  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_DELAY = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_RATE  = RPT_W'(REPEAT_RATE);
  localparam logic [RPT_W-1:0] RPT_ONE   = RPT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DB_W-1:0]        db_cnt;
  logic                   synced;
  logic                   accept;
  logic                   rise;
  logic                   fall;

  bc_state_t              state_q;
  bc_state_t              state_d;
  logic [RPT_W-1:0]       rpt_cnt_q;
  logic [RPT_W-1:0]       rpt_cnt_d;
  logic                   fire_d;

  assign synced = sync_q[SYNC_STAGES-1];
  assign accept = (synced != level) && (db_cnt == DB_LAST);
  assign rise   = accept && synced;
  assign fall   = accept && !synced;

  // Sync chain and debouncer; the strobes fire on the same edge that flips level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      db_cnt   <= '0;
      level    <= 1'b0;
      press    <= 1'b0;
      released <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], btn_raw};
      press    <= rise;
      released <= fall;
      if (synced == level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        level  <= synced;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BC_IDLE;
      rpt_cnt_q <= '0;
      fire      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rpt_cnt_q <= rpt_cnt_d;
      fire      <= fire_d;
    end
  end

  // Leaving on the fall event (not the old level) makes a release beat a coincident repeat fire.
  always_comb begin
    state_d   = state_q;
    rpt_cnt_d = rpt_cnt_q;
    fire_d    = 1'b0;
    case (state_q)
      BC_IDLE: begin
        if (rise) begin
          state_d   = BC_HOLD;
          rpt_cnt_d = RPT_ONE;
          fire_d    = 1'b1;
        end
      end
      BC_HOLD: begin
        if (fall) begin
          state_d   = BC_IDLE;
          rpt_cnt_d = '0;
        end else if (!repeat_en) begin
          rpt_cnt_d = '0;
        end else if (rpt_cnt_q == RPT_DELAY) begin
          state_d   = BC_REPEAT;
          rpt_cnt_d = RPT_ONE;
          fire_d    = 1'b1;
        end else begin
          rpt_cnt_d = rpt_cnt_q + RPT_ONE;
        end
      end
      BC_REPEAT: begin
        if (fall) begin
          state_d   = BC_IDLE;
          rpt_cnt_d = '0;
        end else if (!repeat_en) begin
          state_d   = BC_HOLD;
          rpt_cnt_d = '0;
        end else if (rpt_cnt_q == RPT_RATE) begin
          rpt_cnt_d = RPT_ONE;
          fire_d    = 1'b1;
        end else begin
          rpt_cnt_d = rpt_cnt_q + RPT_ONE;
        end
      end
      default: begin
        state_d   = BC_IDLE;
        rpt_cnt_d = '0;
      end
    endcase
  end

  assign held_long = (state_q == BC_REPEAT);

endmodule

// File: rtl/button_conditioner.sv
// N independent button/switch conditioners; every output is a clk-domain register
// (held_long decodes the registered FSM state only).
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int N            = BC_DEF_N,
  parameter int SYNC_STAGES  = BC_DEF_SYNC_STAGES,
  parameter int DB_CYCLES    = BC_DEF_DB_CYCLES,
  parameter int REPEAT_DELAY = BC_DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = BC_DEF_REPEAT_RATE
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] btn_raw,
  input  logic [N-1:0] repeat_en,
  output logic [N-1:0] level,
  output logic [N-1:0] press,
  output logic [N-1:0] released,
  output logic [N-1:0] fire,
  output logic [N-1:0] held_long
);

  for (genvar i = 0; i < N; i++) begin : g_chan
    btn_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DB_CYCLES    (DB_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_raw   (btn_raw[i]),
      .repeat_en (repeat_en[i]),
      .level     (level[i]),
      .press     (press[i]),
      .released  (released[i]),
      .fire      (fire[i]),
      .held_long (held_long[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboarded bench for button_conditioner: a timestamp-based reference model
// predicts every cycle's outputs, a negedge monitor compares them against the DUT.
module tb_button_conditioner;

  localparam int N     = 4;
  localparam int SYNC  = 2;
  localparam int DB    = 4;
  localparam int DELAY = 10;
  localparam int RATE  = 3;

  typedef struct packed {
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] released;
    logic [N-1:0] fire;
    logic [N-1:0] held_long;
  } resp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] btn_raw;
  logic [N-1:0] repeat_en;
  logic [N-1:0] level;
  logic [N-1:0] press;
  logic [N-1:0] released;
  logic [N-1:0] fire;
  logic [N-1:0] held_long;

  resp_t exp_q[$];
  int    n_vectors     = 0;
  int    n_miscompares = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .N            (N),
    .SYNC_STAGES  (SYNC),
    .DB_CYCLES    (DB),
    .REPEAT_DELAY (DELAY),
    .REPEAT_RATE  (RATE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_raw),
    .repeat_en (repeat_en),
    .level     (level),
    .press     (press),
    .released  (released),
    .fire      (fire),
    .held_long (held_long)
  );

  // Reference model: hist[j] is the raw vector sampled j edges ago. A level is accepted
  // once the synchronised view (raw delayed SYNC edges) shows DB equal samples.
  // Repeat timing is a per-channel timestamp: the edge at which the delay/rate interval began.
  logic [N-1:0] hist[$];
  logic [N-1:0] m_level;
  bit           m_holding[N];
  bit           m_repeating[N];
  bit           m_timed[N];
  int           m_anchor[N];
  int           edge_no = 0;

  always @(posedge clk) begin
    resp_t        e;
    logic [N-1:0] new_level;
    bit           stable;
    logic         v;
    edge_no++;
    e = '0;
    if (!rst_n) begin
      hist.delete();
      repeat (SYNC + DB + 2) hist.push_front('0);
      m_level = '0;
      for (int ch = 0; ch < N; ch++) begin
        m_holding[ch]   = 1'b0;
        m_repeating[ch] = 1'b0;
        m_timed[ch]     = 1'b0;
        m_anchor[ch]    = 0;
      end
    end else begin
      hist.push_front(btn_raw);
      void'(hist.pop_back());
      new_level = m_level;
      for (int ch = 0; ch < N; ch++) begin
        v      = hist[SYNC][ch];
        stable = 1'b1;
        for (int j = SYNC + 1; j < SYNC + DB; j++)
          if (hist[j][ch] != v) stable = 1'b0;
        if (stable) new_level[ch] = v;
        e.press[ch]    = new_level[ch] & ~m_level[ch];
        e.released[ch] = ~new_level[ch] & m_level[ch];
        if (e.press[ch]) begin
          m_holding[ch] = 1'b1;
          m_timed[ch]   = 1'b1;
          m_anchor[ch]  = edge_no;
          e.fire[ch]    = 1'b1;
        end else if (!new_level[ch]) begin
          m_holding[ch]   = 1'b0;
          m_repeating[ch] = 1'b0;
          m_timed[ch]     = 1'b0;
        end else if (!repeat_en[ch]) begin
          m_repeating[ch] = 1'b0;
          m_timed[ch]     = 1'b0;
        end else if (!m_timed[ch]) begin
          m_timed[ch]  = 1'b1;
          m_anchor[ch] = edge_no;
        end else if (!m_repeating[ch] && edge_no - m_anchor[ch] == DELAY) begin
          m_repeating[ch] = 1'b1;
          m_anchor[ch]    = edge_no;
          e.fire[ch]      = 1'b1;
        end else if (m_repeating[ch] && edge_no - m_anchor[ch] == RATE) begin
          m_anchor[ch] = edge_no;
          e.fire[ch]   = 1'b1;
        end
        e.held_long[ch] = m_repeating[ch];
      end
      m_level = new_level;
      e.level = new_level;
    end
    exp_q.push_back(e);
  end

  task automatic checkOutput(input string name, input resp_t exp);
    resp_t got;
    got = {level, press, released, fire, held_long};
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s t=%0t got lvl=%h prs=%h rel=%h fire=%h hl=%h expected lvl=%h prs=%h rel=%h fire=%h hl=%h",
               name, $time, got.level, got.press, got.released, got.fire, got.held_long,
               exp.level, exp.press, exp.released, exp.fire, exp.held_long);
    end
  endtask

  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("cycle", e);
      end
    end
  end

  task automatic applyStimulus(input logic [N-1:0] raw, input logic [N-1:0] en, input int cycles);
    btn_raw   = raw;
    repeat_en = en;
    repeat (cycles) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Asserting reset between edges must clear every output before any clock arrives.
  task automatic pulseReset(input int cycles);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", '0);
    repeat (cycles) begin
      @(negedge clk);
      #1;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] en;
    rst_n     = 1'b0;
    btn_raw   = 4'hF;
    repeat_en = '0;

    // Buttons already held through reset qualify after release.
    applyStimulus(4'hF, 4'h0, 4);
    rst_n = 1'b1;
    applyStimulus(4'hF, 4'h0, 10);
    applyStimulus(4'h0, 4'h0, 12);

    // Short glitch on channel 0.
    applyStimulus(4'b0001, 4'h0, 3);
    applyStimulus(4'h0, 4'h0, 12);

    // Hold with repeat enabled, then release.
    applyStimulus(4'b0010, 4'b0010, 23);
    applyStimulus(4'h0, 4'b0010, 15);

    // Hold without repeat, enable later.
    applyStimulus(4'b0010, 4'h0, 25);
    applyStimulus(4'b0010, 4'b0010, 16);
    applyStimulus(4'h0, 4'h0, 12);

    // Simultaneous presses; channel 3 released on a repeat boundary.
    applyStimulus(4'b1100, 4'b1100, 13);
    applyStimulus(4'b0100, 4'b1100, 10);
    applyStimulus(4'h0, 4'h0, 12);

    // Reset while repeating with the button still held.
    applyStimulus(4'b0010, 4'b0010, 20);
    pulseReset(2);
    applyStimulus(4'b0010, 4'b0010, 12);
    applyStimulus(4'h0, 4'h0, 12);

    // Randomised phase.
    r  = '0;
    en = '0;
    for (int it = 0; it < 250; it++) begin
      r = r ^ N'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) en = N'($urandom_range(0, 15));
      if ($urandom_range(0, 60) == 0) pulseReset($urandom_range(1, 3));
      applyStimulus(r, en, $urandom_range(1, 24));
    end
    applyStimulus(4'h0, 4'h0, 12);

    n_vectors++;
    if (n_vectors < 1000) begin
      n_miscompares++;
      $display("[TB] FAIL vector_count got=%0d required>=1000", n_vectors);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
